// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median window sequencer.
// Tap k sits at row offset TAP_DR[k] and column offset TAP_DC[k] from the centre.
package median_pkg;

  localparam int ROWS = 430;
  localparam int COLS = 554;
  localparam int DW   = 8;
  localparam int AW   = 18;
  localparam int TAPS = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int TAP_DR [TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

endpackage

// File: rtl/median_tap_addr.sv
// Combinational tap address generator: (r, c, k) -> column-major RAM address,
// clamped to the frame, plus a flag telling whether the unclamped tap was inside it.
module median_tap_addr #(
  parameter int ROWS = 430,
  parameter int COLS = 554,
  parameter int AW   = 18,
  parameter int RW   = 9,
  parameter int CW   = 10
) (
  input  logic [RW-1:0] r,
  input  logic [CW-1:0] c,
  input  logic [3:0]    k,
  output logic [AW-1:0] addr,
  output logic          in_range
);
  import median_pkg::*;

  int rr;
  int cc;

  always_comb begin
    rr       = int'(r) + TAP_DR[k];
    cc       = int'(c) + TAP_DC[k];
    in_range = 1'b1;
    if (rr < 0) begin
      rr       = 0;
      in_range = 1'b0;
    end else if (rr > ROWS - 1) begin
      rr       = ROWS - 1;
      in_range = 1'b0;
    end
    if (cc < 0) begin
      cc       = 0;
      in_range = 1'b0;
    end else if (cc > COLS - 1) begin
      cc       = COLS - 1;
      in_range = 1'b0;
    end
    addr = AW'(cc * ROWS + rr);
  end

endmodule

// File: rtl/median_window_sequencer.sv
// Frame scanner feeding 3x3 windows from a single-port pixel RAM to the median core.
// Build option MEDIAN_SEQ_ZERO_PAD_EN: out-of-frame taps read as 0 instead of edge replication.
module median_window_sequencer #(
  parameter int ROWS = median_pkg::ROWS,
  parameter int COLS = median_pkg::COLS,
  parameter int DW   = median_pkg::DW,
  parameter int AW   = median_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [DW-1:0]        mem_rd_data,
  output logic [9*DW-1:0]      win_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [AW-1:0]        pix_idx,
  output logic [2:0]           dbg_state
);
  import median_pkg::*;

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

`ifdef MEDIAN_SEQ_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  state_t          state, state_nx;
  logic [RW-1:0]   r;
  logic [CW-1:0]   c;
  logic [3:0]      k;
  logic [AW-1:0]   lin;
  logic [DW-1:0]   slot [TAPS-1];
  logic            skip_q;
  logic [AW-1:0]   tap_addr;
  logic            tap_in_range;
  logic            tap_skip;
  logic            last_pix;
  logic [TAPS*DW-1:0] win_nx;

  median_tap_addr #(
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW),
    .RW   (RW),
    .CW   (CW)
  ) u_tap_addr (
    .r        (r),
    .c        (c),
    .k        (k),
    .addr     (tap_addr),
    .in_range (tap_in_range)
  );

  assign tap_skip  = ZERO_PAD && !tap_in_range;
  assign last_pix  = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));
  assign dbg_state = state;

  // Handshake: a window transfers on a cycle where win_valid && win_ready. win_valid
  // stays high with win_data/pix_idx frozen until that happens; ready alone does nothing.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    win_valid = 1'b0;
    case (state)
      IDLE: if (start) state_nx = FETCH;
      FETCH: begin
        busy      = 1'b1;
        mem_rd_en = !tap_skip;
        mem_addr  = tap_skip ? '0 : tap_addr;
        if (k == 4'd8) state_nx = CAPT;
      end
      CAPT: begin
        busy     = 1'b1;
        state_nx = PRESENT;
      end
      PRESENT: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (win_ready) state_nx = last_pix ? DONE : FETCH;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The last tap is still on the RAM bus during CAPT, so it goes straight into the window.
  always_comb begin
    win_nx = '0;
    for (int i = 0; i < TAPS - 1; i++) win_nx[i*DW +: DW] = slot[i];
    win_nx[(TAPS-1)*DW +: DW] = skip_q ? '0 : mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      r        <= '0;
      c        <= '0;
      k        <= '0;
      lin      <= '0;
      skip_q   <= 1'b0;
      win_data <= '0;
      pix_idx  <= '0;
      for (int i = 0; i < TAPS - 1; i++) slot[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            r   <= '0;
            c   <= '0;
            k   <= '0;
            lin <= '0;
          end
        end
        FETCH: begin
          if (k != 4'd8) k <= k + 4'd1;
          skip_q <= tap_skip;
          if (k != 4'd0) slot[3'(k - 4'd1)] <= skip_q ? '0 : mem_rd_data;
        end
        CAPT: begin
          win_data <= win_nx;
          pix_idx  <= lin;
        end
        PRESENT: begin
          if (win_ready) begin
            k <= '0;
            if (!last_pix) begin
              lin <= lin + 1'b1;
              if (r == RW'(ROWS - 1)) begin
                r <= '0;
                c <= c + 1'b1;
              end else begin
                r <= r + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_sequencer.sv
// Bench for median_window_sequencer on a 4x3 frame with mem[a] = a.
// Expected windows come from a small clamp/zero-pad model and are queued per frame.
`timescale 1ns/1ps
module tb_median_window_sequencer;

  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int DW   = 8;
  localparam int AW   = 18;
  localparam int NPIX = ROWS * COLS;
  localparam int W    = 9 * DW + AW;

`ifdef MEDIAN_SEQ_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
  localparam logic [9*DW-1:0] CORNER = {8'd5, 8'd1, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`else
  localparam bit ZP = 1'b0;
  localparam logic [9*DW-1:0] CORNER = {8'd5, 8'd1, 8'd1, 8'd4, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0};
`endif
  localparam logic [9*DW-1:0] INTERIOR = {8'd10, 8'd6, 8'd2, 8'd9, 8'd5, 8'd1, 8'd8, 8'd4, 8'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic win_ready = 1'b0;
  logic busy, done, mem_rd_en, win_valid;
  logic [AW-1:0] mem_addr, pix_idx;
  logic [DW-1:0] mem_rd_data;
  logic [9*DW-1:0] win_data;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  median_window_sequencer #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DW   (DW),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .win_data    (win_data),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .pix_idx     (pix_idx),
    .dbg_state   (dbg_state)
  );

  // clock / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rd_data <= mem_rd_en ? DW'(mem_addr) : 8'hEE;

  function automatic logic [AW:0] tap_model(int p, int k);
    int r = p % ROWS;
    int c = p / ROWS;
    int rr;
    int cc;
    bit inr = 1'b1;
    rr = r + k / 3 - 1;
    cc = c + k % 3 - 1;
    if (rr < 0) begin rr = 0; inr = 1'b0; end
    else if (rr > ROWS - 1) begin rr = ROWS - 1; inr = 1'b0; end
    if (cc < 0) begin cc = 0; inr = 1'b0; end
    else if (cc > COLS - 1) begin cc = COLS - 1; inr = 1'b0; end
    return {inr, AW'(cc * ROWS + rr)};
  endfunction

  function automatic logic [W-1:0] win_model(int p);
    logic [9*DW-1:0] w;
    logic [AW:0] t;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      t = tap_model(p, k);
      w[k*DW +: DW] = (ZP && !t[AW]) ? '0 : DW'(t[AW-1:0]);
    end
    return {AW'(p), w};
  endfunction

  function automatic int cycle();
    return cyc - base;
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    base = cyc - 1;
  endtask

  task automatic push_frame();
    for (int p = 0; p < NPIX; p++) exp_q.push_back(win_model(p));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_valid"}, win_valid, 0);
    check({tag, "_win"}, win_data, 0);
    check({tag, "_pix"}, pix_idx, 0);
  endtask

  // scoreboard: pop on every accepted window
  always @(negedge clk) begin
    if (!rst && win_valid && win_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) check("win_unexpected", 1, 0);
      else check("win_sb", {pix_idx, win_data}, exp_q.pop_front());
      if (pix_idx == 5) check("win_interior", win_data, INTERIOR);
    end
    if (!rst && done) done_cnt++;
  end

  initial begin
    logic [AW:0] t;
    int rel;

    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Frame A: corner window, fetch pattern, backpressure
    push_frame();
    win_ready = 1'b0;
    start_frame();
    while (!win_valid && cycle() < 40) begin
      if (cycle() <= 9) begin
        t = tap_model(0, cycle() - 1);
        check("fetch_rd_en", mem_rd_en, !ZP || t[AW]);
        if (mem_rd_en) check("fetch_addr", mem_addr, t[AW-1:0]);
        check("fetch_busy", busy, 1);
      end else begin
        check("capt_rd_en", mem_rd_en, 0);
      end
      step();
    end
    check("first_valid_cyc", cycle(), 11);
    check("corner_win", win_data, CORNER);
    check("corner_pix", pix_idx, 0);
    repeat (5) begin
      step();
      check("bp_valid", win_valid, 1);
      check("bp_rd_en", mem_rd_en, 0);
      check("bp_hold", {pix_idx, win_data}, win_model(0));
    end
    win_ready = 1'b1;
    rel = cycle();
    step();
    while (!win_valid && cycle() - rel < 40) step();
    check("bp_gap", cycle() - rel, 11);
    while (!done && cycle() < 400) step();
    check("a_done_seen", done, 1);
    step();
    check("a_handshakes", hs_cnt, NPIX);
    check("a_q_empty", exp_q.size(), 0);

    // Frame B: ready held high, start while busy and in DONE
    hs_cnt = 0;
    done_cnt = 0;
    push_frame();
    win_ready = 1'b1;
    start_frame();
    repeat (40) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("b_busy_mid", busy, 1);
    while (!done && cycle() < 400) step();
    check("b_done_cyc", cycle(), 11 * NPIX + 1);
    check("b_done_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("b_done_pulse", done, 0);
    check("b_busy_after", busy, 0);
    step();
    check("b_busy_after2", busy, 0);
    check("b_done_cnt", done_cnt, 1);
    check("b_handshakes", hs_cnt, NPIX);
    check("b_q_empty", exp_q.size(), 0);

    // Frame C: reset mid-fetch, then restart
    win_ready = 1'b0;
    start_frame();
    while (cycle() < 5) step();
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(win_model(0));
    step();
    start_frame();
    while (!win_valid && cycle() < 40) step();
    check("c_first_valid_cyc", cycle(), 11);
    check("c_corner_win", win_data, CORNER);
    check("c_corner_pix", pix_idx, 0);
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    check("c_q_empty", exp_q.size(), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/median_window_sequencer.md
Name: median_window_sequencer

Overview:
- Sequences the 3x3 median filter datapath over a full frame held in a single-port pixel RAM.
- Scans every pixel, issues the 9 neighbour reads one per cycle, and handles frame borders.
- Presents the assembled window to the filter with a valid/ready handshake and signals frame completion.
- Sits between the frame RAM and the median filter core; replaces free-running index stepping with a proper controller.

Parameters:
- ROWS, 430, column height and memory stride; address = c*ROWS + r.
- COLS, 554, number of columns.
- DW, 8, pixel width.
- AW, 18, RAM address width; must satisfy 2**AW >= ROWS*COLS.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last window handshake
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  AW  RAM read address
- mem_rd_data  in  DW  RAM data, valid exactly 1 cycle after mem_rd_en
- win_data  out  9*DW  window; tap k occupies bits [k*DW +: DW]
- win_valid  out  1  window valid
- win_ready  in  1  filter accepts window
- pix_idx  out  AW  linear address of the centre pixel of win_data

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE; r, c and the tap counter are cleared. Reset has priority in every state, including mid-frame; the next start begins at pixel 0.
- Tap k (0..8): dr = k/3 - 1, dc = k%3 - 1.
  - Tap 0 = (r-1, c-1); tap 1 = (r-1, c); tap 4 = centre; tap 8 = (r+1, c+1).
- Border handling: out-of-range coordinates are clamped to [0, ROWS-1] and [0, COLS-1] (edge replication). Every tap is read from RAM.
- Scan order: r fastest, then c, starting at (0,0). pix_idx increments by 1 per window.
- FSM states:
  - IDLE: start=1 -> FETCH with k=0, busy=1.
  - FETCH: mem_rd_en=1, mem_addr = address of tap k. The word returned next cycle is stored in tap slot k-1. At k=8 -> CAPT.
  - CAPT: store tap 8; mem_rd_en=0 -> PRESENT.
  - PRESENT: win_valid=1.
    - On win_valid & win_ready: if (r,c) = (ROWS-1, COLS-1) -> DONE; else advance (r wraps to 0 and c increments) -> FETCH.
  - DONE: done=1, busy=0, win_valid=0 -> IDLE.
- Timing:
  - Start sampled at edge 0; FETCH covers cycles 1-9, CAPT cycle 10, first win_valid in cycle 11.
  - With win_ready held high: 11 cycles per pixel.
  - Frame time = 11*ROWS*COLS + 1 cycles to the done pulse.
- Backpressure: while win_valid=1 and win_ready=0, win_data and pix_idx are held stable and no RAM reads are issued. win_ready high before win_valid has no effect.
- start while busy is ignored. start in the DONE cycle is ignored.
- win_data and pix_idx change only on entry to PRESENT. Taps are registered; there is no combinational path from mem_rd_data to win_data.

Optional Feature:
- Macro: MEDIAN_SEQ_ZERO_PAD_EN.
- Defined: out-of-range taps are not clamped. Their slot is loaded with 0, and mem_rd_en stays low in that tap's FETCH cycle. Cycle count is unchanged (11 per pixel).
- Undefined: edge replication as described above.

Decomposition:
- Package median_pkg: ROWS, COLS, DW, AW, TAPS=9, the state enum (IDLE, FETCH, CAPT, PRESENT, DONE), and the tap dr/dc offset tables.
- Sub-module median_tap_addr: combinational. Maps (r, c, k) to clamped address plus an in_range flag; the zero-pad build uses the in_range flag.

Test Plan:
All scenarios use ROWS=4, COLS=3, mem[a]=a.
1. Corner window: start pulse at edge 0 -> win_valid first high in cycle 11, pix_idx=0, taps 0..8 = {0,0,4,0,0,4,1,1,5}.
2. Interior window: handshake to pixel r=1, c=1 -> pix_idx=5, taps = {0,4,8,1,5,9,2,6,10}.
3. Backpressure: hold win_ready=0 for 5 cycles in PRESENT -> win_valid stays 1, win_data/pix_idx unchanged, mem_rd_en=0 throughout; next window follows 11 cycles after release.
4. Full frame, win_ready=1: exactly 12 handshakes with pix_idx 0..11; done single pulse at cycle 133; busy low afterwards; a start during busy changes nothing.
5. Reset mid-FETCH (cycle 5): all outputs 0 next cycle; a later start restarts at pix_idx=0 with the scenario-1 window.
6. MEDIAN_SEQ_ZERO_PAD_EN defined: corner window taps = {0,0,0,0,0,4,0,1,5}; mem_rd_en low in the FETCH cycles of taps 0,1,2,3,6.
